// File: rtl/s4ga_pkg.sv
// s4ga_pkg: shared types, constants and helpers for the s4ga_stream LUT fabric.

package s4ga_pkg;

    // Configuration stream phase within one LUT frame
    typedef enum logic {
        INDEX = 1'b0,
        MASK  = 1'b1
    } phase_e;

    // Index decode codes, expressed as offsets below the all-ones index value
    localparam int IDX_CONST1 = 0;
    localparam int IDX_CARRY  = 1;

    // Ceiling divide: number of m-bit segments needed to carry n bits
    function automatic int SEGS(input int n, input int m);
        return (n + m - 1) / m;
    endfunction

endpackage

// File: rtl/s4ga_frame_ctr.sv
// s4ga_frame_ctr: LUT/field/segment sequencing for the configuration stream.
// Tracks n (current LUT), k (field within the frame, k==K is the mask) and
// seg (segment within the field). Only beats advance the counters.

module s4ga_frame_ctr
    import s4ga_pkg::*;
#(
    parameter int N         = 89,
    parameter int K         = 5,
    parameter int IDX_SEGS  = 2,
    parameter int MASK_SEGS = 8,
    parameter int N_W       = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           beat_i,
    output phase_e         phase_o,
    output logic           last_seg_o,
    output logic           last_lut_o,
    output logic [N_W-1:0] n_o
);

    localparam int K_W     = $clog2(K + 1);
    localparam int SEG_MAX = (IDX_SEGS > MASK_SEGS) ? IDX_SEGS : MASK_SEGS;
    localparam int SEG_W   = $clog2(SEG_MAX + 1);

    logic [N_W-1:0]   n_q, n_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [SEG_W-1:0] seg_q, seg_d;

    assign phase_o    = (k_q == K_W'(K)) ? MASK : INDEX;
    assign last_seg_o = (phase_o == INDEX) ? (seg_q == SEG_W'(IDX_SEGS - 1))
                                           : (seg_q == SEG_W'(MASK_SEGS - 1));
    assign last_lut_o = (n_q == N_W'(N - 1));
    assign n_o        = n_q;

    // Next-count logic: seg wraps per field, k wraps per frame, n wraps per sweep
    always_comb begin
        n_d   = n_q;
        k_d   = k_q;
        seg_d = seg_q;
        if (beat_i) begin
            if (!last_seg_o) begin
                seg_d = seg_q + 1'b1;
            end else begin
                seg_d = '0;
                if (phase_o == INDEX) begin
                    k_d = k_q + 1'b1;
                end else begin
                    k_d = '0;
                    n_d = last_lut_o ? '0 : n_q + 1'b1;
                end
            end
        end
    end

    // Counter registers; reset aborts any partial frame
    always_ff @(posedge clk) begin
        if (rst) begin
            n_q   <= '0;
            k_q   <= '0;
            seg_q <= '0;
        end else begin
            n_q   <= n_d;
            k_q   <= k_d;
            seg_q <= seg_d;
        end
    end

endmodule

// File: rtl/s4ga_stream.sv
// s4ga_stream: serial-configured K-input LUT fabric with a valid/ready
// configuration stream. One LUT is evaluated per received frame; the ring of
// LUT results rotates on every beat so index fields address it relatively.
// Optional feature: define S4GA_CARRY_EN to add the half-LUT carry register q,
// selected by index code all-ones minus 1.

module s4ga_stream
    import s4ga_pkg::*;
#(
    parameter int N    = 89,
    parameter int K    = 5,
    parameter int I    = 2,
    parameter int O    = 8,
    parameter int SI_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SI_W-1:0] si,
    input  logic            si_valid,
    output logic            si_ready,
    input  logic [I-1:0]    inputs,
    output logic [O-1:0]    outputs,
    output logic            frame_done
);

    localparam int N_W       = $clog2(N);
    localparam int MASK_W    = 1 << K;
    localparam int MAX_W     = (MASK_W > N_W) ? MASK_W : N_W;
    localparam int IDX_SEGS  = SEGS(N_W, SI_W);
    localparam int MASK_SEGS = SEGS(MASK_W, SI_W);
    localparam int MAX_SEGS  = SEGS(MAX_W, SI_W);
    localparam int SR_W      = (MAX_SEGS > 1) ? (MAX_SEGS - 1) * SI_W : SI_W;
    localparam int FLD_W     = SR_W + SI_W;

    localparam logic [N_W-1:0] IDX_ONE = N_W'((1 << N_W) - 1 - IDX_CONST1);
`ifdef S4GA_CARRY_EN
    localparam logic [N_W-1:0] IDX_Q   = N_W'((1 << N_W) - 1 - IDX_CARRY);
`endif

    logic                beat;
    phase_e              phase;
    logic                last_seg;
    logic                last_lut;
    logic [N_W-1:0]      n_cur;
    logic                mask_end;

    logic [N-1:0]        luts_q, luts_d;
    logic [SR_W-1:0]     sr_q, sr_d;
    logic [K-1:0]        ins_q, ins_d;
    logic [O-1:0]        pend_q, pend_d;
    logic [O-1:0]        out_q, out_d;
    logic                fd_q, fd_d;

    logic [FLD_W-1:0]    field;
    logic [N_W-1:0]      idx;
    logic [MASK_W-1:0]   mask;
    logic                dec_bit;
    logic                in_sel;
    logic                in_bit;
    logic                lut;

    // The block never back-pressures once out of reset
    assign si_ready = ~rst;
    assign beat     = si_valid & si_ready;
    assign mask_end = beat && (phase == MASK) && last_seg;

    // Current segment completes the field held in the segment shift register
    assign field = {sr_q, si};
    assign idx   = field[N_W-1:0];
    assign mask  = field[MASK_W-1:0];

    s4ga_frame_ctr #(
        .N         (N),
        .K         (K),
        .IDX_SEGS  (IDX_SEGS),
        .MASK_SEGS (MASK_SEGS),
        .N_W       (N_W)
    ) u_frame_ctr (
        .clk        (clk),
        .rst        (rst),
        .beat_i     (beat),
        .phase_o    (phase),
        .last_seg_o (last_seg),
        .last_lut_o (last_lut),
        .n_o        (n_cur)
    );

`ifdef S4GA_CARRY_EN
    logic q_q, q_d;

    // Half-LUT carry: low half of the mask addressed by the low K-1 inputs
    always_comb begin
        q_d = q_q;
        if (mask_end) q_d = mask[MASK_W/2-1:0][ins_q[K-2:0]];
    end

    // Carry register
    always_ff @(posedge clk) begin
        if (rst) q_q <= 1'b0;
        else     q_q <= q_d;
    end
`endif

    // Index decode: constant 1, optional carry, ring tap, otherwise 0
    always_comb begin
        dec_bit = 1'b0;
        if (idx == IDX_ONE) begin
            dec_bit = 1'b1;
        end
`ifdef S4GA_CARRY_EN
        else if (idx == IDX_Q) begin
            dec_bit = q_q;
        end
`endif
        else if (idx < N_W'(N)) begin
            dec_bit = luts_q[idx];
        end
    end

    // External input select for the first I LUTs
    always_comb begin
        in_sel = (n_cur < N_W'(I));
        in_bit = 1'b0;
        for (int j = 0; j < I; j++) begin
            if (n_cur == N_W'(j)) in_bit = inputs[j];
        end
    end

    // Bit entering the ring: evaluated LUT on the final mask beat, zero in reset, else recirculate
    always_comb begin
        lut = luts_q[N-1];
        if (rst) begin
            lut = 1'b0;
        end else if (mask_end) begin
            lut = in_sel ? in_bit : mask[ins_q];
        end
    end

    // Next-state for the ring and datapath registers
    always_comb begin
        luts_d = luts_q;
        sr_d   = sr_q;
        ins_d  = ins_q;
        pend_d = pend_q;
        out_d  = out_q;
        fd_d   = 1'b0;
        if (rst || beat) luts_d = {luts_q[N-2:0], lut};
        if (beat) begin
            sr_d = field[SR_W-1:0];
            if ((phase == INDEX) && last_seg) ins_d = {ins_q[K-2:0], dec_bit};
            if (mask_end) begin
                pend_d = {pend_q[O-2:0], lut};
                if (last_lut) begin
                    out_d = {pend_q[O-2:0], lut};
                    fd_d  = 1'b1;
                end
            end
        end
    end

    // Ring has no reset value of its own; holding reset flushes it with zeros
    always_ff @(posedge clk) begin
        luts_q <= luts_d;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q   <= '0;
            ins_q  <= '0;
            pend_q <= '0;
            out_q  <= '0;
            fd_q   <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            ins_q  <= ins_d;
            pend_q <= pend_d;
            out_q  <= out_d;
            fd_q   <= fd_d;
        end
    end

    assign outputs    = out_q;
    assign frame_done = fd_q;

endmodule
